// File: rtl/mtm_alu_pkg.sv
// Shared constants, frame/op encodings and the CRC4 helper for the mtm ALU serial front end.
package mtm_alu_pkg;

  typedef enum logic {
    BYTE_DATA = 1'b0,
    BYTE_CMD  = 1'b1
  } byte_type_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [7:0] ERR_DATA = 8'b1100_1001;
  localparam logic [7:0] ERR_CRC  = 8'b1010_0101;
  localparam logic [7:0] ERR_OP   = 8'b1001_0011;

  // Widest CRC input: two 64-bit operands plus the 4-bit {1'b1, op} trailer.
  localparam int unsigned CRC_MAX_BITS = 132;

  // x^4+x+1, MSB first; only the low `len` bits of data take part.
  function automatic logic [3:0] crc4_calc(input logic [CRC_MAX_BITS-1:0] data,
                                           input int unsigned len,
                                           input logic [3:0] init);
    logic [3:0] crc;
    logic       fb;
    crc = init;
    for (int unsigned i = CRC_MAX_BITS; i > 0; i--) begin
      if (i <= len) begin
        fb  = crc[3] ^ data[i-1];
        crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
    end
    return crc;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver: start 0, type, 8 payload bits MSB first, stop 1; resyncs after a framing fault.
module mtm_alu_frame_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       byte_vld,
  output logic       byte_type,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TYPE   = 3'd1;
  localparam logic [2:0] S_BITS   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_RESYNC = 3'd4;

  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [3:0] idle_cnt;
  logic [7:0] shreg;
  logic       type_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shreg     <= '0;
      type_q    <= 1'b0;
      byte_vld  <= 1'b0;
      byte_type <= BYTE_DATA;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: if (!sin) state <= S_TYPE;
        S_TYPE: begin
          type_q  <= sin;
          bit_cnt <= '0;
          state   <= S_BITS;
        end
        S_BITS: begin
          shreg   <= {shreg[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_STOP;
        end
        S_STOP: begin
          if (sin) begin
            byte_vld  <= 1'b1;
            byte_type <= type_q;
            rx_byte   <= shreg;
            state     <= S_IDLE;
          end else begin
            frame_err <= 1'b1;
            idle_cnt  <= '0;
            state     <= S_RESYNC;
          end
        end
        S_RESYNC: begin
          // Need 11 consecutive idle-high samples before trusting a start bit again.
          if (!sin)                  idle_cnt <= '0;
          else if (idle_cnt == 4'd10) state   <= S_IDLE;
          else                       idle_cnt <= idle_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_deserializer_p.sv
// Packet assembly, CRC/op/length checks and single-entry valid/ready result register for the mtm ALU.
module mtm_alu_deserializer_p
  import mtm_alu_pkg::*;
#(
  parameter int unsigned OPERAND_BYTES = 4,
  parameter logic [3:0]  CRC_INIT      = 4'b0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sin,
  output logic [8*OPERAND_BYTES-1:0]   a_o,
  output logic [8*OPERAND_BYTES-1:0]   b_o,
  output logic [2:0]                   op_o,
  output logic                         err_o,
  output logic [7:0]                   err_ctl_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         ovf_o
);

  localparam int unsigned W  = 8 * OPERAND_BYTES;
  localparam int unsigned NB = 2 * OPERAND_BYTES;
  localparam int unsigned CW = $clog2(NB + 2);

  logic                    byte_vld;
  logic                    byte_type;
  logic [7:0]              rx_byte;
  logic                    frame_err;

  logic [CW-1:0]           byte_cnt;
  logic [2*W-1:0]          pkt_buf;
  logic [W-1:0]            pkt_a;
  logic [W-1:0]            pkt_b;
  logic [2:0]              cmd_op;
  logic [3:0]              cmd_crc;
  logic [3:0]              calc_crc;
  logic [CRC_MAX_BITS-1:0] crc_in;
  logic                    res_evt;
  logic                    res_err;
  logic [7:0]              res_code;

  mtm_alu_frame_rx u_frame_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .byte_vld  (byte_vld),
    .byte_type (byte_type),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_comb begin
    pkt_a   = pkt_buf[2*W-1:W];
    pkt_b   = pkt_buf[W-1:0];
    cmd_op  = rx_byte[6:4];
    cmd_crc = rx_byte[3:0];
    crc_in  = '0;
    crc_in[2*W+3:0] = {pkt_b, pkt_a, 1'b1, cmd_op};
    calc_crc = crc4_calc(crc_in, 2*W + 4, CRC_INIT);
    res_evt  = frame_err | (byte_vld & (byte_type == BYTE_CMD));
    res_err  = 1'b1;
    res_code = ERR_DATA;
    if (frame_err || (byte_cnt != CW'(NB))) begin
      res_code = ERR_DATA;
    end else if (calc_crc != cmd_crc) begin
      res_code = ERR_CRC;
    end else if (!op_legal(cmd_op)) begin
      res_code = ERR_OP;
    end else begin
      res_err  = 1'b0;
      res_code = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      pkt_buf   <= '0;
      a_o       <= '0;
      b_o       <= '0;
      op_o      <= '0;
      err_o     <= 1'b0;
      err_ctl_o <= '0;
      valid_o   <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      ovf_o <= 1'b0;

      // A CMD byte or a framing fault always closes the packet, whatever its outcome.
      if (frame_err || (byte_vld && (byte_type == BYTE_CMD))) begin
        byte_cnt <= '0;
        pkt_buf  <= '0;
      end else if (byte_vld) begin
        pkt_buf <= {pkt_buf[2*W-9:0], rx_byte};
        if (byte_cnt != CW'(NB + 1)) byte_cnt <= byte_cnt + CW'(1);
      end

      if (res_evt) begin
        if (valid_o && !ready_i) begin
          ovf_o <= 1'b1;
        end else begin
          valid_o <= 1'b1;
          if (res_err) begin
            err_o     <= 1'b1;
            err_ctl_o <= res_code;
          end else begin
            a_o       <= pkt_a;
            b_o       <= pkt_b;
            op_o      <= cmd_op;
            err_o     <= 1'b0;
            err_ctl_o <= '0;
          end
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
